// File: rtl/gppcu_instr_dispatcher_pkg.sv
// Shared widths and dispatcher state encoding for the GPPCU instruction feeder.
package gppcu_instr_dispatcher_pkg;

    localparam int DEF_DBW        = 32;
    localparam int DEF_IABW       = 10;
    localparam int DEF_FIFO_DEPTH = 4;

    // 2'b10 and 2'b11 are spare encodings; the FSM recovers from them to IDLE.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01
    } dispState_t;

endpackage

// File: rtl/gppcu_instr_dispatcher_sync_fifo.sv
// Show-ahead synchronous FIFO used as the dispatcher's prefetch buffer.
module gppcu_sync_fifo
    import gppcu_instr_dispatcher_pkg::*;
#(
    parameter int DBW        = DEF_DBW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                          iACLK,
    input  logic                          inRST,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          clear,
    input  logic [DBW-1:0]                din,
    output logic [DBW-1:0]                dout,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DBW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]  wrPtr;
    logic [AW-1:0]  rdPtr;

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wrPtr] <= din;
                wrPtr      <= wrPtr + AW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[rdPtr];

endmodule

// File: rtl/gppcu_instr_dispatcher.sv
// Streams a block of instructions from synchronous-read instruction memory into
// the GPPCU core through a credit-limited prefetch FIFO.
module gppcu_instr_dispatcher
    import gppcu_instr_dispatcher_pkg::*;
#(
    parameter int DBW        = DEF_DBW,
    parameter int IABW       = DEF_IABW,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic            iACLK,
    input  logic            inRST,
    input  logic            iSTART,
    input  logic [IABW-1:0] iSTART_ADDR,
    input  logic [IABW:0]   iINSTR_COUNT,
    input  logic            iABORT,
    output logic            oBUSY,
    output logic            oDONE,
    output logic [IABW-1:0] oIMEM_ADDR,
    output logic            oIMEM_RD,
    input  logic [DBW-1:0]  iIMEM_RDATA,
    output logic [DBW-1:0]  oINSTR,
    output logic            oINSTR_VALID,
    input  logic            iINSTR_READY,
    output dispState_t      oSTATE
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    dispState_t      state;
    logic [IABW-1:0] addrPtr;
    logic [IABW:0]   issueLeft;
    logic            inflight;
    logic            busyQ;
    logic            doneQ;
    logic [CW-1:0]   fifoCount;
    logic [CW:0]     credit;
    logic            issue;
    logic            push;
    logic            pop;
    logic            drained;

    // Words in the FIFO plus the one read in flight never exceed the depth,
    // so a returning word always has a slot.
    assign credit  = {1'b0, fifoCount} + {{CW{1'b0}}, inflight};
    assign issue   = (state == S_RUN) && (issueLeft != '0) && (credit < DEPTH_C);
    assign drained = (issueLeft == '0) && !inflight && (fifoCount == '0);

    // Core handshake: an instruction moves on any edge where oINSTR_VALID and
    // iINSTR_READY are both high; while VALID is high and READY low, oINSTR and
    // oINSTR_VALID hold. VALID never depends on READY.
    assign push = inflight && !iABORT;
    assign pop  = oINSTR_VALID && iINSTR_READY;

    always_ff @(posedge iACLK or negedge inRST) begin
        if (!inRST) begin
            state     <= S_IDLE;
            addrPtr   <= '0;
            issueLeft <= '0;
            inflight  <= 1'b0;
            busyQ     <= 1'b0;
            doneQ     <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (iABORT) begin
                state     <= S_IDLE;
                issueLeft <= '0;
                inflight  <= 1'b0;
                busyQ     <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    addrPtr   <= addrPtr + IABW'(1);
                    issueLeft <= issueLeft - (IABW + 1)'(1);
                end
                case (state)
                    S_IDLE: begin
                        if (iSTART) begin
                            state     <= S_RUN;
                            busyQ     <= 1'b1;
                            addrPtr   <= iSTART_ADDR;
                            issueLeft <= iINSTR_COUNT;
                        end
                    end
                    S_RUN: begin
                        if (drained) begin
                            state <= S_IDLE;
                            busyQ <= 1'b0;
                            doneQ <= 1'b1;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busyQ <= 1'b0;
                    end
                endcase
            end
        end
    end

    gppcu_sync_fifo #(
        .DBW        (DBW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) uFifo (
        .iACLK (iACLK),
        .inRST (inRST),
        .push  (push),
        .pop   (pop),
        .clear (iABORT),
        .din   (iIMEM_RDATA),
        .dout  (oINSTR),
        .count (fifoCount)
    );

    assign oINSTR_VALID = (fifoCount != '0);
    assign oIMEM_RD     = issue;
    assign oIMEM_ADDR   = addrPtr;
    assign oBUSY        = busyQ;
    assign oDONE        = doneQ;
    assign oSTATE       = state;

endmodule
